// File: rtl/sorted_ram_writer_pkg.sv
// Shared sizing and FSM state encoding for the sorted RAM insertion block.
package sorted_ram_writer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT1,
        WAIT2,
        SHIFT,
        PLACE,
        DONE
    } state_e;

endpackage

// File: rtl/sorted_ram_writer_dp.sv
// Datapath for sorted_ram_writer: value/temp/slot/count/overflow registers and shift comparator.
// SORTED_RAM_WRITER_DESC_EN selects a descending table.
module sorted_ram_writer_dp
    import sorted_ram_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              accept_i,
    input  logic              reject_i,
    input  logic              clear_i,
    input  logic              load_t_i,
    input  logic              dec_idx_i,
    input  logic              inc_cnt_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] v_o,
    output logic [DATA_W-1:0] t_o,
    output logic [ADDR_W-1:0] slot_addr_o,
    output logic [ADDR_W-1:0] prev_addr_o,
    output logic              idx_zero_o,
    output logic              full_o,
    output logic              shift_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o
);

    logic [DATA_W-1:0] v_q, v_d;
    logic [DATA_W-1:0] t_q, t_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  idx_dec;

    assign idx_dec    = idx_q - CNT_W'(1);
    assign idx_zero_o = (idx_q == '0);
    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    // Slot indices reaching the RAM are always < DEPTH, so the top bit drops out.
    assign slot_addr_o = idx_q[ADDR_W-1:0];
    assign prev_addr_o = idx_dec[ADDR_W-1:0];

`ifdef SORTED_RAM_WRITER_DESC_EN
    assign shift_o = (rdata_i < v_q);
`else
    assign shift_o = (rdata_i > v_q);
`endif

    always_comb begin
        v_d   = v_q;
        t_d   = t_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept_i) begin
            v_d   = data_i;
            idx_d = cnt_q;
            ovf_d = 1'b0;
        end
        if (reject_i)                  ovf_d = 1'b1;
        if (clear_i)                   cnt_d = '0;
        if (load_t_i)                  t_d   = rdata_i;
        if (dec_idx_i && !idx_zero_o)  idx_d = idx_dec;
        if (inc_cnt_i && !full_o)      cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            t_q   <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            t_q   <= t_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign v_o        = v_q;
    assign t_o        = t_q;
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/sorted_ram_writer.sv
// Insertion-sort writer keeping RAM[0..count-1] ordered; FSM here, datapath in sorted_ram_writer_dp.
// Define SORTED_RAM_WRITER_DESC_EN for a descending table (default ascending).
module sorted_ram_writer
    import sorted_ram_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  count
);

    state_e state_q, state_d;

    logic              accept, reject, clr_cnt, load_t, dec_idx, inc_cnt;
    logic [DATA_W-1:0] v, t;
    logic [ADDR_W-1:0] slot_addr, prev_addr;
    logic              idx_zero, full, shift;

    sorted_ram_writer_dp u_dp (
        .clk         (clk),
        .reset       (reset),
        .accept_i    (accept),
        .reject_i    (reject),
        .clear_i     (clr_cnt),
        .load_t_i    (load_t),
        .dec_idx_i   (dec_idx),
        .inc_cnt_i   (inc_cnt),
        .data_i      (data_in),
        .rdata_i     (ram_rdata),
        .v_o         (v),
        .t_o         (t),
        .slot_addr_o (slot_addr),
        .prev_addr_o (prev_addr),
        .idx_zero_o  (idx_zero),
        .full_o      (full),
        .shift_o     (shift),
        .count_o     (count),
        .overflow_o  (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        clr_cnt   = 1'b0;
        load_t    = 1'b0;
        dec_idx   = 1'b0;
        inc_cnt   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (full) begin
                        reject  = 1'b1;
                        state_d = DONE;
                    end else begin
                        accept  = 1'b1;
                        state_d = CHECK;
                    end
                end else if (clear) begin
                    clr_cnt = 1'b1;
                end
            end
            CHECK: begin
                if (idx_zero) begin
                    state_d = PLACE;
                end else begin
                    ram_addr = prev_addr;
                    state_d  = WAIT1;
                end
            end
            WAIT1: begin
                ram_addr = prev_addr;
                state_d  = WAIT2;
            end
            // Read data for prev_addr lands here; equal entries stay put for stability.
            WAIT2: begin
                ram_addr = prev_addr;
                if (shift) begin
                    load_t  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = PLACE;
                end
            end
            SHIFT: begin
                ram_we    = 1'b1;
                ram_addr  = slot_addr;
                ram_wdata = t;
                dec_idx   = 1'b1;
                state_d   = CHECK;
            end
            PLACE: begin
                ram_we    = 1'b1;
                ram_addr  = slot_addr;
                ram_wdata = v;
                inc_cnt   = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sorted_ram_writer.sv
// Scoreboard bench for sorted_ram_writer with a 32x8 RAM model of 2-cycle read latency.
module tb_sorted_ram_writer;
    import sorted_ram_writer_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start, clear;
    logic [7:0] data_in, ram_rdata, ram_wdata;
    logic [4:0] ram_addr;
    logic       ram_we, done, overflow;
    logic [5:0] count;

    always #5 clk = ~clk;

    sorted_ram_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .clear     (clear),
        .data_in   (data_in),
        .ram_rdata (ram_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .done      (done),
        .overflow  (overflow),
        .count     (count)
    );

    logic [7:0]  mem [32];
    logic [7:0]  rd1, rd2;
    int unsigned total_wr = 0;
    logic [4:0]  last_wr_addr = '0;

    assign ram_rdata = rd2;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            total_wr      <= total_wr + 1;
            last_wr_addr  <= ram_addr;
        end
        rd1 <= mem[ram_addr];
        rd2 <= rd1;
    end

    typedef struct {
        int unsigned lat;
        int unsigned cnt;
        int unsigned ovf;
        int unsigned writes;
        int unsigned addr;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  exp_mem [32];
    int unsigned exp_count = 0;
    int unsigned exp_ovf = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit goes_before(input logic [7:0] newv, input logic [7:0] old);
`ifdef SORTED_RAM_WRITER_DESC_EN
        return old < newv;
`else
        return old > newv;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; clear = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        check("rst_we", ram_we, 0);
        check("rst_ovf", overflow, 0);
        check("rst_addr", ram_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
        exp_ovf = 0;
    endtask

    task automatic insert(input logic [7:0] val);
        exp_t        e, got;
        int unsigned pos, k, edges, wr0;
        bit          seen;
        if (exp_count == 32) begin
            exp_ovf = 1;
            e = '{lat: 1, cnt: 32, ovf: 1, writes: 0, addr: 0};
        end else begin
            pos = exp_count;
            while (pos > 0 && goes_before(val, exp_mem[pos-1])) begin
                exp_mem[pos] = exp_mem[pos-1];
                pos--;
            end
            exp_mem[pos] = val;
            k = exp_count - pos;
            e.lat    = (k == exp_count) ? 4*k + 3 : 4*k + 5;
            e.writes = k + 1;
            e.addr   = pos;
            exp_count++;
            exp_ovf  = 0;
            e.cnt    = exp_count;
            e.ovf    = 0;
        end
        sb.push_back(e);

        @(negedge clk);
        data_in = val; start = 1'b1;
        wr0 = total_wr; edges = 0; seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(posedge clk); edges++; #1;
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        got = sb.pop_front();
        check("latency", edges, got.lat);
        check("count", count, got.cnt);
        check("overflow", overflow, got.ovf);
        check("writes", total_wr - wr0, got.writes);
        if (got.writes > 0) check("place_addr", last_wr_addr, got.addr);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("done_drop", done, 0);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 32; i++)
            if (i < int'(exp_count)) check(tag, mem[i], exp_mem[i]);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0; data_in = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        do_reset();
        insert(8'd20);
        check_table("ram_one");
        insert(8'd10);
        insert(8'd30);
        insert(8'd15);
        check_table("ram_four");

        do_reset();
        insert(8'd7);
        insert(8'd7);
        check_table("ram_equal");

        do_reset();
        insert(8'd10);
        insert(8'd20);
        insert(8'd5);
        check_table("ram_three");

        do_reset();
        for (int i = 0; i < 32; i++) insert(8'($urandom_range(0, 255)));
        insert(8'd99);
        insert(8'd0);
        check_table("ram_full");
        check("full_ovf_held", overflow, 1);

        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1;
        check("clear_full", count, 0);
        @(negedge clk); clear = 1'b0;
        exp_count = 0;
        insert(8'd255);
        insert(8'd0);
        check_table("ram_after_clear");

        do_reset();
        insert(8'd50);
        insert(8'd60);
        insert(8'd70);
        @(negedge clk);
        data_in = 8'd10; start = 1'b1;
        begin
            bit hit = 0;
            for (int c = 0; c < 50 && !hit; c++) begin
                @(posedge clk); #1;
                if (dut.state_q == SHIFT) hit = 1;
            end
            check("reach_shift", hit, 1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("midshift_state", 32'(dut.state_q), 32'(IDLE));
        check("midshift_count", count, 0);
        check("midshift_we", ram_we, 0);
        check("midshift_done", done, 0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        exp_count = 0; exp_ovf = 0;

        for (int i = 0; i < 5; i++) insert(8'(i * 3 + 1));
        check("pre_clear", count, 5);
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1;
        check("clear_count", count, 0);
        @(negedge clk); clear = 1'b0;
        exp_count = 0;
        insert(8'd42);
        check_table("ram_post_clear");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
